hdmi_pll_reconfig_ctrl: RTL

- Sequences run-time reprogramming of the HDMI pixel-clock PLL (single output, 112 MHz reference) through the PLL reconfiguration core's Avalon-MM management port.
- Accepts a pre-encoded N/M/C0/K counter set from the video-mode logic.
- Writes the set in a fixed register order, starts reconfiguration, polls for completion, then qualifies PLL lock before reporting done.
- Sits between the scaler/video-mode register block and the reconfiguration core.

---
 rtl/pll_reconfig_pkg.sv | 32 +++
 rtl/pll_avmm_master.sv | 52 +++++
 rtl/hdmi_pll_reconfig_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/pll_reconfig_pkg.sv
// Shared definitions for the HDMI PLL reconfiguration controller:
// reconfig-core register map, counter-field type and sequencer states.
package pll_reconfig_pkg;

   typedef logic [5:0] mgmt_addr_t;

   localparam mgmt_addr_t ADDR_MODE   = 6'h00;
   localparam mgmt_addr_t ADDR_STATUS = 6'h01;
   localparam mgmt_addr_t ADDR_START  = 6'h02;
   localparam mgmt_addr_t ADDR_N      = 6'h03;
   localparam mgmt_addr_t ADDR_M      = 6'h04;
   localparam mgmt_addr_t ADDR_C      = 6'h05;
   localparam mgmt_addr_t ADDR_K      = 6'h07;

   // {odd, bypass, hi[7:0], lo[7:0]}
   typedef logic [17:0] pll_cnt_t;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_WR_MODE,
      ST_WR_N,
      ST_WR_M,
      ST_WR_K,
      ST_WR_C0,
      ST_WR_START,
      ST_RD_STAT,
      ST_LOCK_WAIT,
      ST_DONE,
      ST_ERR
   } pll_state_t;

endpackage

// File: rtl/pll_avmm_master.sv
// Single-transfer Avalon-MM master: launches one read or write on i_go and
// holds address/data until the slave drops waitrequest.
module pll_avmm_master
   import pll_reconfig_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_go,
   input  logic        i_rd,
   input  mgmt_addr_t  i_addr,
   input  logic [31:0] i_wdata,
   output logic        o_done,
   output logic [31:0] o_rdata,
   output mgmt_addr_t  o_mgmt_address,
   output logic        o_mgmt_write,
   output logic        o_mgmt_read,
   output logic [31:0] o_mgmt_writedata,
   input  logic [31:0] i_mgmt_readdata,
   input  logic        i_mgmt_waitrequest
);

   logic        r_active;
   logic        r_rd;
   mgmt_addr_t  r_addr;
   logic [31:0] r_wdata;

   // A new go is only taken while idle, so the completing cycle is always
   // followed by at least one cycle with both strobes low.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_active <= 1'b0;
         r_rd     <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
      end else if (r_active) begin
         if (!i_mgmt_waitrequest) r_active <= 1'b0;
      end else if (i_go) begin
         r_active <= 1'b1;
         r_rd     <= i_rd;
         r_addr   <= i_addr;
         r_wdata  <= i_wdata;
      end
   end

   assign o_done           = r_active & ~i_mgmt_waitrequest;
   assign o_rdata          = i_mgmt_readdata;
   assign o_mgmt_address   = r_addr;
   assign o_mgmt_write     = r_active & ~r_rd;
   assign o_mgmt_read      = r_active & r_rd;
   assign o_mgmt_writedata = r_wdata;

endmodule

// File: rtl/hdmi_pll_reconfig_ctrl.sv
// HDMI pixel-clock PLL reconfiguration sequencer: writes N/M/(K)/C0, starts
// reconfiguration, polls status, then qualifies lock before reporting done.
module hdmi_pll_reconfig_ctrl
   import pll_reconfig_pkg::*;
#(
   parameter int unsigned POLL_TIMEOUT = 4095,
   parameter int unsigned LOCK_TIMEOUT = 65535,
   parameter int unsigned LOCK_STABLE  = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cfg_req,
   input  logic [17:0] cfg_n,
   input  logic [17:0] cfg_m,
   input  logic [17:0] cfg_c0,
   input  logic [31:0] cfg_k,
   input  logic        cfg_frac,
   output logic        cfg_busy,
   output logic        cfg_done,
   output logic        cfg_err,
   input  logic        pll_locked,
   output logic [5:0]  mgmt_address,
   output logic        mgmt_write,
   output logic        mgmt_read,
   output logic [31:0] mgmt_writedata,
   input  logic [31:0] mgmt_readdata,
   input  logic        mgmt_waitrequest
);

   localparam int unsigned PW = $clog2(POLL_TIMEOUT + 1);
   localparam int unsigned TW = $clog2(LOCK_TIMEOUT + 1);
   localparam int unsigned SW = $clog2(LOCK_STABLE + 1);
   localparam logic [PW-1:0] POLL_MAX   = PW'(POLL_TIMEOUT);
   localparam logic [TW-1:0] LOCK_MAX   = TW'(LOCK_TIMEOUT);
   localparam logic [SW-1:0] STABLE_MAX = SW'(LOCK_STABLE);

   pll_state_t    r_state, w_state_next;
   pll_cnt_t      r_n, r_m, r_c0;
   logic [31:0]   r_k;
   logic          r_frac;
   logic          r_err;
   logic          r_lock_meta, r_lock_sync;
   logic [PW-1:0] r_poll_cnt, w_poll_inc;
   logic [TW-1:0] r_lock_cnt, w_lock_inc;
   logic [SW-1:0] r_stable_cnt, w_stable_next;

   logic          w_go, w_rd, w_xfer_done;
   mgmt_addr_t    w_addr;
   logic [31:0]   w_wdata, w_rdata;
   logic          w_unused_rdata;

   assign w_unused_rdata = ^w_rdata[31:1];

   assign w_poll_inc    = (r_poll_cnt == POLL_MAX) ? r_poll_cnt : r_poll_cnt + PW'(1);
   assign w_lock_inc    = (r_lock_cnt == LOCK_MAX) ? r_lock_cnt : r_lock_cnt + TW'(1);
   assign w_stable_next = !r_lock_sync ? '0 :
                          (r_stable_cnt == STABLE_MAX) ? r_stable_cnt : r_stable_cnt + SW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lock_meta <= 1'b0;
         r_lock_sync <= 1'b0;
      end else begin
         r_lock_meta <= pll_locked;
         r_lock_sync <= r_lock_meta;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_go         = 1'b0;
      w_rd         = 1'b0;
      w_addr       = ADDR_MODE;
      w_wdata      = '0;
      unique case (r_state)
         ST_IDLE:      if (cfg_req) w_state_next = ST_WR_MODE;
         ST_WR_MODE: begin
            w_go    = 1'b1;
            w_wdata = 32'd1;
            if (w_xfer_done) w_state_next = ST_WR_N;
         end
         ST_WR_N: begin
            w_go    = 1'b1;
            w_addr  = ADDR_N;
            w_wdata = {14'b0, r_n};
            if (w_xfer_done) w_state_next = ST_WR_M;
         end
         ST_WR_M: begin
            w_go    = 1'b1;
            w_addr  = ADDR_M;
            w_wdata = {14'b0, r_m};
            if (w_xfer_done) w_state_next = r_frac ? ST_WR_K : ST_WR_C0;
         end
         ST_WR_K: begin
            w_go    = 1'b1;
            w_addr  = ADDR_K;
            w_wdata = r_k;
            if (w_xfer_done) w_state_next = ST_WR_C0;
         end
         ST_WR_C0: begin
            w_go    = 1'b1;
            w_addr  = ADDR_C;
            w_wdata = {9'b0, 5'd0, r_c0};
            if (w_xfer_done) w_state_next = ST_WR_START;
         end
         ST_WR_START: begin
            w_go   = 1'b1;
            w_addr = ADDR_START;
            if (w_xfer_done) w_state_next = ST_RD_STAT;
         end
         ST_RD_STAT: begin
            w_go   = 1'b1;
            w_rd   = 1'b1;
            w_addr = ADDR_STATUS;
            if (w_xfer_done) begin
               if (w_rdata[0])                w_state_next = ST_LOCK_WAIT;
               else if (w_poll_inc >= POLL_MAX) w_state_next = ST_ERR;
            end
         end
         // Lock qualification is checked before the timeout so success wins a tie.
         ST_LOCK_WAIT: begin
            if (w_stable_next >= STABLE_MAX)  w_state_next = ST_DONE;
            else if (w_lock_inc >= LOCK_MAX) w_state_next = ST_ERR;
         end
         ST_DONE:      w_state_next = ST_IDLE;
         ST_ERR:       w_state_next = ST_IDLE;
         default:      w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_n          <= '0;
         r_m          <= '0;
         r_c0         <= '0;
         r_k          <= '0;
         r_frac       <= 1'b0;
         r_err        <= 1'b0;
         r_poll_cnt   <= '0;
         r_lock_cnt   <= '0;
         r_stable_cnt <= '0;
      end else begin
         if (r_state == ST_IDLE && cfg_req) begin
            r_n          <= cfg_n;
            r_m          <= cfg_m;
            r_c0         <= cfg_c0;
            r_k          <= cfg_k;
            r_frac       <= cfg_frac;
            r_err        <= 1'b0;
            r_poll_cnt   <= '0;
            r_lock_cnt   <= '0;
            r_stable_cnt <= '0;
         end
         if (r_state == ST_RD_STAT && w_xfer_done && !w_rdata[0]) r_poll_cnt <= w_poll_inc;
         if (r_state == ST_LOCK_WAIT) begin
            r_lock_cnt   <= w_lock_inc;
            r_stable_cnt <= w_stable_next;
         end
         if (w_state_next == ST_ERR) r_err <= 1'b1;
      end
   end

   assign cfg_busy = (r_state != ST_IDLE) && (r_state != ST_DONE) && (r_state != ST_ERR);
   assign cfg_done = (r_state == ST_DONE);
   assign cfg_err  = r_err;

   pll_avmm_master u_avmm (
      .i_clk              (clk),
      .i_rst_n            (rst_n),
      .i_go               (w_go),
      .i_rd               (w_rd),
      .i_addr             (w_addr),
      .i_wdata            (w_wdata),
      .o_done             (w_xfer_done),
      .o_rdata            (w_rdata),
      .o_mgmt_address     (mgmt_address),
      .o_mgmt_write       (mgmt_write),
      .o_mgmt_read        (mgmt_read),
      .o_mgmt_writedata   (mgmt_writedata),
      .i_mgmt_readdata    (mgmt_readdata),
      .i_mgmt_waitrequest (mgmt_waitrequest)
   );

endmodule
